// File: rtl/value_pred_checker_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | value_pred_checker_if : prediction / result / recovery / training bus   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface value_pred_checker_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
);
   logic                  pred_valid;
   logic [ADDR_WIDTH-1:0] pred_pc;
   logic [DATA_WIDTH-1:0] pred_data;
   logic                  pred_ready;

   logic                  res_valid;
   logic                  res_predicted;
   logic [ADDR_WIDTH-1:0] res_pc;
   logic [DATA_WIDTH-1:0] res_data;

   logic                  flush;

   logic                  recover_valid;
   logic [ADDR_WIDTH-1:0] recover_pc;
   logic [DATA_WIDTH-1:0] recover_data;
   logic                  recover_ack;

   logic                  train_valid;
   logic [ADDR_WIDTH-1:0] train_pc;
   logic [DATA_WIDTH-1:0] train_data;
   logic                  train_correct;

   logic                  proto_err;
   logic [CNT_WIDTH-1:0]  correct_cnt;
   logic [CNT_WIDTH-1:0]  mispred_cnt;

   modport master (
      output pred_valid, pred_pc, pred_data, res_valid, res_predicted,
             res_pc, res_data, flush, recover_ack,
      input  pred_ready, recover_valid, recover_pc, recover_data,
             train_valid, train_pc, train_data, train_correct,
             proto_err, correct_cnt, mispred_cnt
   );

   modport slave (
      input  pred_valid, pred_pc, pred_data, res_valid, res_predicted,
             res_pc, res_data, flush, recover_ack,
      output pred_ready, recover_valid, recover_pc, recover_data,
             train_valid, train_pc, train_data, train_correct,
             proto_err, correct_cnt, mispred_cnt
   );
endinterface
`default_nettype wire

// File: rtl/value_pred_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | value_pred_checker : checks returning load data against queued value    |
// | predictions; emits training updates and misprediction recovery.        |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module value_pred_checker #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  wire logic           clk,
   input  wire logic           rst,
   value_pred_checker_if.slave bus
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = IW + 1;
   localparam logic [PW-1:0]        PTR_ONE = PW'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TRACK   = 2'd1,
      RECOVER = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;

   logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem [DEPTH];

   logic                  recover_valid_q, recover_valid_d;
   logic [ADDR_WIDTH-1:0] recover_pc_q, recover_pc_d;
   logic [DATA_WIDTH-1:0] recover_data_q, recover_data_d;
   logic                  train_valid_q, train_valid_d;
   logic                  train_correct_q, train_correct_d;
   logic [ADDR_WIDTH-1:0] train_pc_q, train_pc_d;
   logic [DATA_WIDTH-1:0] train_data_q, train_data_d;
   logic                  proto_err_q, proto_err_d;
   logic [CNT_WIDTH-1:0]  correct_cnt_q, correct_cnt_d;
   logic [CNT_WIDTH-1:0]  mispred_cnt_q, mispred_cnt_d;

   logic                  empty, full, in_recover;
   logic                  pred_res, pop_ok, pc_match, data_match, mispredict;
   logic                  pred_ready, push;
   logic [ADDR_WIDTH-1:0] head_pc;
   logic [DATA_WIDTH-1:0] head_data;

   assign empty      = (rd_q == wr_q);
   assign full       = (rd_q[IW-1:0] == wr_q[IW-1:0]) && (rd_q[PW-1] != wr_q[PW-1]);
   assign in_recover = (state_q == RECOVER);
   assign head_pc    = pc_mem[rd_q[IW-1:0]];
   assign head_data  = data_mem[rd_q[IW-1:0]];

   assign pred_res   = bus.res_valid && bus.res_predicted && !in_recover;
   assign pop_ok     = pred_res && !empty;
   assign pc_match   = (bus.res_pc == head_pc);
   assign data_match = (bus.res_data == head_data);
   assign mispredict = pop_ok && pc_match && !data_match;

   // A pop in the same cycle frees the slot a full queue would otherwise block.
   assign pred_ready = !in_recover && (!full || (pop_ok && !mispredict));
   assign push       = bus.pred_valid && pred_ready && !bus.flush;

   always_comb begin
      state_d         = state_q;
      rd_d            = rd_q;
      wr_d            = wr_q;
      recover_valid_d = recover_valid_q;
      recover_pc_d    = recover_pc_q;
      recover_data_d  = recover_data_q;
      train_valid_d   = 1'b0;
      train_correct_d = 1'b0;
      train_pc_d      = train_pc_q;
      train_data_d    = train_data_q;
      proto_err_d     = proto_err_q;
      correct_cnt_d   = correct_cnt_q;
      mispred_cnt_d   = mispred_cnt_q;

      if (bus.res_valid && !bus.res_predicted) begin
         train_valid_d = 1'b1;
         train_pc_d    = bus.res_pc;
         train_data_d  = bus.res_data;
      end

      if (pred_res) begin
         if (empty) begin
            proto_err_d = 1'b1;
         end else if (!pc_match) begin
            proto_err_d = 1'b1;
            rd_d        = rd_q + PTR_ONE;
         end else begin
            rd_d          = rd_q + PTR_ONE;
            train_valid_d = 1'b1;
            train_pc_d    = bus.res_pc;
            train_data_d  = bus.res_data;
            if (data_match) begin
               train_correct_d = 1'b1;
               if (correct_cnt_q != '1) correct_cnt_d = correct_cnt_q + CNT_ONE;
            end else begin
               if (mispred_cnt_q != '1) mispred_cnt_d = mispred_cnt_q + CNT_ONE;
               recover_valid_d = 1'b1;
               recover_pc_d    = bus.res_pc;
               recover_data_d  = bus.res_data;
            end
         end
      end

      if (push) wr_d = wr_q + PTR_ONE;

      // Entries behind a mispredicted load are younger and get squashed with it.
      if (mispredict || bus.flush) begin
         rd_d = '0;
         wr_d = '0;
      end

      case (state_q)
         RECOVER: begin
            if (bus.recover_ack) begin
               recover_valid_d = 1'b0;
               state_d         = IDLE;
            end
         end
         default: begin
            if (mispredict)        state_d = RECOVER;
            else if (wr_d == rd_d) state_d = IDLE;
            else                   state_d = TRACK;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         rd_q            <= '0;
         wr_q            <= '0;
         recover_valid_q <= 1'b0;
         recover_pc_q    <= '0;
         recover_data_q  <= '0;
         train_valid_q   <= 1'b0;
         train_correct_q <= 1'b0;
         train_pc_q      <= '0;
         train_data_q    <= '0;
         proto_err_q     <= 1'b0;
         correct_cnt_q   <= '0;
         mispred_cnt_q   <= '0;
      end else begin
         state_q         <= state_d;
         rd_q            <= rd_d;
         wr_q            <= wr_d;
         recover_valid_q <= recover_valid_d;
         recover_pc_q    <= recover_pc_d;
         recover_data_q  <= recover_data_d;
         train_valid_q   <= train_valid_d;
         train_correct_q <= train_correct_d;
         train_pc_q      <= train_pc_d;
         train_data_q    <= train_data_d;
         proto_err_q     <= proto_err_d;
         correct_cnt_q   <= correct_cnt_d;
         mispred_cnt_q   <= mispred_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_q[IW-1:0]]   <= bus.pred_pc;
         data_mem[wr_q[IW-1:0]] <= bus.pred_data;
      end
   end

   assign bus.pred_ready    = pred_ready;
   assign bus.recover_valid = recover_valid_q;
   assign bus.recover_pc    = recover_pc_q;
   assign bus.recover_data  = recover_data_q;
   assign bus.train_valid   = train_valid_q;
   assign bus.train_correct = train_correct_q;
   assign bus.train_pc      = train_pc_q;
   assign bus.train_data    = train_data_q;
   assign bus.proto_err     = proto_err_q;
   assign bus.correct_cnt   = correct_cnt_q;
   assign bus.mispred_cnt   = mispred_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_value_pred_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_value_pred_checker : directed bench for value_pred_checker           |
// | rev 1.1                                                                  |
// +--------------------------------------------------------------------------+
module tb_value_pred_checker;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   failed    = 0;

    always #5 clk = ~clk;

    value_pred_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    value_pred_checker #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic ok);
        tests_run++;
        if (ok !== 1'b1) begin
            failed++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.pred_valid    = 1'b0;
        bus.pred_pc       = '0;
        bus.pred_data     = '0;
        bus.res_valid     = 1'b0;
        bus.res_predicted = 1'b0;
        bus.res_pc        = '0;
        bus.res_data      = '0;
        bus.flush         = 1'b0;
        bus.recover_ack   = 1'b0;
    endtask

    task automatic push(input logic [AW-1:0] pc, input logic [DW-1:0] d);
        bus.pred_valid = 1'b1;
        bus.pred_pc    = pc;
        bus.pred_data  = d;
        tick();
        bus.pred_valid = 1'b0;
    endtask

    task automatic result(input logic pr, input logic [AW-1:0] pc, input logic [DW-1:0] d);
        bus.res_valid     = 1'b1;
        bus.res_predicted = pr;
        bus.res_pc        = pc;
        bus.res_data      = d;
    endtask

    initial begin
        idle_in();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_recover_valid", bus.recover_valid === 1'b0);
        chk("reset_train_valid", bus.train_valid === 1'b0);
        chk("reset_correct_cnt", bus.correct_cnt === 3'd0);
        chk("reset_mispred_cnt", bus.mispred_cnt === 3'd0);
        chk("reset_proto_err", bus.proto_err === 1'b0);
        chk("reset_pred_ready", bus.pred_ready === 1'b1);

        // 1: correct prediction
        push(32'h100, 32'h5);
        result(1'b1, 32'h100, 32'h5);
        tick();
        idle_in();
        chk("t1_train_valid", bus.train_valid === 1'b1);
        chk("t1_train_correct", bus.train_correct === 1'b1);
        chk("t1_train_pc", bus.train_pc === 32'h100);
        chk("t1_train_data", bus.train_data === 32'h5);
        chk("t1_correct_cnt", bus.correct_cnt === 3'd1);
        chk("t1_recover_valid", bus.recover_valid === 1'b0);
        tick();
        chk("t1_train_pulse_end", bus.train_valid === 1'b0);

        // 2: misprediction with delayed ack
        push(32'h100, 32'h5);
        push(32'h104, 32'h9);
        result(1'b1, 32'h100, 32'h7);
        tick();
        idle_in();
        chk("t2_recover_valid", bus.recover_valid === 1'b1);
        chk("t2_recover_pc", bus.recover_pc === 32'h100);
        chk("t2_recover_data", bus.recover_data === 32'h7);
        chk("t2_mispred_cnt", bus.mispred_cnt === 3'd1);
        chk("t2_train_valid", bus.train_valid === 1'b1);
        chk("t2_train_correct", bus.train_correct === 1'b0);
        chk("t2_pred_ready", bus.pred_ready === 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.pred_valid = 1'b1;
            bus.pred_pc    = 32'h900;
            result(1'b1, 32'h104, 32'h9);
            tick();
            idle_in();
            chk("t2_hold_valid", bus.recover_valid === 1'b1);
            chk("t2_hold_pc", bus.recover_pc === 32'h100);
            chk("t2_hold_data", bus.recover_data === 32'h7);
        end
        chk("t2_ignored_result_cnt", bus.correct_cnt === 3'd1);
        bus.recover_ack = 1'b1;
        tick();
        bus.recover_ack = 1'b0;
        chk("t2_ack_deassert", bus.recover_valid === 1'b0);
        chk("t2_ready_after_ack", bus.pred_ready === 1'b1);

        // 3: fill; 0x104 must be gone so three pushes leave room
        push(32'h200, 32'h1);
        push(32'h204, 32'h2);
        push(32'h208, 32'h3);
        chk("t3_ready_at_3", bus.pred_ready === 1'b1);
        push(32'h20C, 32'h4);
        chk("t3_full_not_ready", bus.pred_ready === 1'b0);
        result(1'b1, 32'h200, 32'h1);
        bus.pred_valid = 1'b1;
        bus.pred_pc    = 32'h210;
        bus.pred_data  = 32'h5;
        #1;
        chk("t3_ready_on_pop", bus.pred_ready === 1'b1);
        tick();
        bus.pred_valid = 1'b0;
        bus.res_valid  = 1'b0;
        #1;
        chk("t3_pop_correct", bus.train_correct === 1'b1);
        chk("t3_still_full", bus.pred_ready === 1'b0);
        for (int i = 1; i < 5; i++) begin
            result(1'b1, 32'h200 + 32'(4 * i), 32'(i + 1));
            tick();
            chk("t3_order_valid", bus.train_valid === 1'b1);
            chk("t3_order_correct", bus.train_correct === 1'b1);
            chk("t3_order_pc", bus.train_pc === 32'h200 + 32'(4 * i));
        end
        idle_in();
        chk("t3_correct_cnt", bus.correct_cnt === 3'd6);
        chk("t3_proto_clean", bus.proto_err === 1'b0);

        // full queue, head mispredicts: no push; ack in first cycle
        push(32'h300, 32'h0);
        push(32'h304, 32'h0);
        push(32'h308, 32'h0);
        push(32'h30C, 32'h0);
        result(1'b1, 32'h300, 32'h1);
        bus.pred_valid = 1'b1;
        bus.pred_pc    = 32'h310;
        #1;
        chk("full_mispred_ready", bus.pred_ready === 1'b0);
        tick();
        idle_in();
        chk("full_mispred_recover", bus.recover_valid === 1'b1);
        chk("full_mispred_cnt", bus.mispred_cnt === 3'd2);
        bus.recover_ack = 1'b1;
        tick();
        bus.recover_ack = 1'b0;
        chk("first_cycle_ack", bus.recover_valid === 1'b0);

        // 4: unpredicted result leaves the queue alone
        push(32'h400, 32'h8);
        result(1'b0, 32'h200, 32'hAB);
        tick();
        idle_in();
        chk("t4_train_valid", bus.train_valid === 1'b1);
        chk("t4_train_correct", bus.train_correct === 1'b0);
        chk("t4_train_pc", bus.train_pc === 32'h200);
        chk("t4_train_data", bus.train_data === 32'hAB);
        chk("t4_correct_cnt", bus.correct_cnt === 3'd6);
        chk("t4_mispred_cnt", bus.mispred_cnt === 3'd2);
        result(1'b1, 32'h400, 32'h8);
        tick();
        chk("t4_queue_kept", bus.train_correct === 1'b1);
        chk("t4_cnt_7", bus.correct_cnt === 3'd7);
        idle_in();
        push(32'h404, 32'h1);
        result(1'b1, 32'h404, 32'h1);
        tick();
        idle_in();
        chk("sat_correct_cnt", bus.correct_cnt === 3'd7);

        // 5: flush beats a same-cycle push, then a stray result is a protocol error
        push(32'h500, 32'h1);
        push(32'h504, 32'h2);
        bus.flush      = 1'b1;
        bus.pred_valid = 1'b1;
        bus.pred_pc    = 32'h508;
        tick();
        idle_in();
        result(1'b1, 32'h500, 32'h1);
        tick();
        idle_in();
        chk("t5_proto_err", bus.proto_err === 1'b1);
        chk("t5_no_train", bus.train_valid === 1'b0);
        chk("t5_cnt_unchanged", bus.correct_cnt === 3'd7);
        tick();
        tick();
        chk("t5_proto_sticky", bus.proto_err === 1'b1);

        // 6: reset during recovery
        push(32'h600, 32'h1);
        result(1'b1, 32'h600, 32'h2);
        tick();
        idle_in();
        chk("t6_in_recover", bus.recover_valid === 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_recover_cleared", bus.recover_valid === 1'b0);
        chk("t6_correct_cnt", bus.correct_cnt === 3'd0);
        chk("t6_mispred_cnt", bus.mispred_cnt === 3'd0);
        chk("t6_proto_err", bus.proto_err === 1'b0);
        chk("t6_pred_ready", bus.pred_ready === 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/value_pred_checker.md
Name: value_pred_checker

Overview:
- Consumer-side counterpart of the load value prediction table.
- Records each value prediction issued at EX in an in-order outstanding queue.
- When the load's real data returns at MEM, compares it against the recorded prediction and issues a registered verdict:
  - a training update back to the table,
  - on mismatch, a recovery request to the pipeline control (re-steer to the load PC, forward the correct data).
- Sits between the MEM-stage d_cache result path and the hazard/recovery controller.

Parameters:
- DEPTH, 4, outstanding predicted loads tracked. Power of two, ≥2.
- ADDR_WIDTH, 32, PC width.
- DATA_WIDTH, 32, load data width.
- CNT_WIDTH, 16, statistics counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pred_valid  in  1  table issued a prediction this cycle.
- pred_pc  in  ADDR_WIDTH  PC of the predicted load.
- pred_data  in  DATA_WIDTH  predicted value.
- pred_ready  out  1  queue can accept a prediction. Combinational.
- res_valid  in  1  a load's data returned at MEM this cycle.
- res_predicted  in  1  that load was value-predicted.
- res_pc  in  ADDR_WIDTH  PC of the returning load.
- res_data  in  DATA_WIDTH  actual load data.
- flush  in  1  pipeline squash from another source (branch recovery).
- recover_valid  out  1  value misprediction recovery request.
- recover_pc  out  ADDR_WIDTH  PC to re-steer to (the load PC).
- recover_data  out  DATA_WIDTH  correct load value.
- recover_ack  in  1  controller accepted the recovery.
- train_valid  out  1  training update valid. One-cycle pulse.
- train_pc  out  ADDR_WIDTH  PC to train.
- train_data  out  DATA_WIDTH  actual value.
- train_correct  out  1  1 = prediction matched; 0 = mismatch or unpredicted load.
- proto_err  out  1  sticky; set when a predicted result PC differs from the queue-head PC.
- correct_cnt  out  CNT_WIDTH  correct predictions. Saturating.
- mispred_cnt  out  CNT_WIDTH  mispredictions. Saturating.

Behaviour:

Reset:
- Queue empty; state IDLE.
- All outputs 0, including both counters and proto_err.
- A reset asserted mid-recovery drops the pending request without an ack.

States:
- IDLE: queue empty.
- TRACK: queue non-empty.
- RECOVER: request outstanding.

Queue and handshakes:
- In-order circular buffer, DEPTH entries, each holding {pc, data}.
- Read/write pointers are log2(DEPTH)+1 bits. The extra MSB separates full from empty; pointers wrap modulo 2*DEPTH.
- pred_ready = !full && state != RECOVER.
- A push occurs on pred_valid && pred_ready. pred_valid while not ready is dropped; the table must hold off.
- Push and pop in the same cycle are allowed when full: the pop frees the slot first, so pred_ready is 1 when full and a predicted result pops this cycle.
  - Exception: pred_ready is 0 in that cycle if the popped entry mispredicts.

Predicted result (res_valid && res_predicted, state != RECOVER):
- Queue empty → set proto_err; no other action.
- res_pc ≠ head pc → set proto_err, pop the head, emit no verdict.
- Otherwise pop the head and compare all DATA_WIDTH bits of res_data against the head data.
  - Match: next cycle train_valid=1, train_correct=1, train_pc/train_data = res_pc/res_data; correct_cnt+1.
  - Mismatch: next cycle train_valid=1, train_correct=0; mispred_cnt+1.
    - Enter RECOVER with recover_valid=1, recover_pc=res_pc, recover_data=res_data.
    - All remaining entries are cleared at that edge; they are younger and will be squashed.

Unpredicted result (res_valid && !res_predicted):
- Next cycle train_valid=1, train_correct=0 (allocation training).
- No queue effect; allowed in any state.

RECOVER:
- recover_valid, recover_pc and recover_data are held stable until the cycle recover_ack=1.
- The ack may arrive in the first cycle. On the edge after ack: deassert; go to IDLE.
- pred_valid is ignored.
- A predicted result is ignored: no pop, no train, no count.

flush:
- Clears the queue at the next edge. TRACK → IDLE.
- Does not cancel an outstanding recovery.
- Has priority over a same-cycle push; a same-cycle result is still trained.

Counters:
- Saturate at all-ones; no wrap.

Latency:
- One cycle from res_valid to train/recover outputs.
- Back-to-back results produce back-to-back train pulses.

Test Plan:
1. Push pc=0x100 data=0x5; result pc=0x100 data=0x5 → next cycle train_valid=1, train_correct=1, correct_cnt=1, recover_valid=0, queue empty.
2. Push 0x100/0x5 and 0x104/0x9; result 0x100 data=0x7 → recover_valid=1, recover_pc=0x100, recover_data=0x7, mispred_cnt=1, pred_ready=0; hold recover_ack=0 for 3 cycles (outputs stable), then ack → IDLE, queue empty, 0x104 entry gone.
3. Fill 4 entries → pred_ready=0. Same cycle: correct result for the head plus pred_valid → push accepted; count stays 4; entries return in order.
4. Result with res_predicted=0, pc=0x200, data=0xAB → train_valid=1, train_correct=0, counters unchanged, queue unchanged.
5. Push 2 entries, assert flush → queue empty next cycle. A later predicted result → proto_err=1, stays set until rst.
6. Assert rst during RECOVER → next cycle recover_valid=0, counters 0, pred_ready=1.
